// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: scanner state encoding, blank code and active-low {a..g} segment table
package seven_seg_pkg;
  typedef enum logic [1:0] {IDLE, SHOW, GUARD} state_e;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  // Entry [c] is the pattern for code c; codes 11-15 are blank.
  localparam logic [15:0][6:0] SEG_TABLE = {
    {5{7'b1111111}}, 7'b0001000, 7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000,
    7'b0100100, 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
endpackage

// File: rtl/seven_seg_if.sv
// seven_seg_if: control, digit-load and display signals of the four-digit scanner
interface seven_seg_if;
  logic        en;
  logic [15:0] digits_in;
  logic        digits_valid;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  modport master(output en, digits_in, digits_valid, input seg, an, frame_done);
  modport slave(input en, digits_in, digits_valid, output seg, an, frame_done);
endinterface

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: one 4-bit code to active-low segment pattern
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[code_i];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 4-digit driver with guard gaps and frame-aligned updates.
// Define SEVEN_SEG_LZ_BLANK_EN to blank leading zeros on digits 3..1.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100000,
  parameter int DEAD_CYCLES  = 1000
) (
  input logic       clk,
  input logic       rst,
  seven_seg_if.slave bus
);
  localparam int CMAX = DIGIT_PERIOD > DEAD_CYCLES ? DIGIT_PERIOD : DEAD_CYCLES;
  localparam int CW = $clog2(CMAX);
  localparam logic [CW-1:0] SHOW_LAST = CW'(DIGIT_PERIOD - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(DEAD_CYCLES - 1);
  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] an_q, an_d;
  logic fd_q, fd_d;
  logic [15:0] act_q, pend_q;
  logic pf_q;
  logic [3:0] raw, code;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q + 1'b1;
    if (!bus.en) begin
      state_d = IDLE;
      idx_d = 2'd0;
      cnt_d = '0;
    end else if (state_q == IDLE) begin
      state_d = SHOW;
      idx_d = 2'd0;
      cnt_d = '0;
    end else if (state_q == SHOW && cnt_q == SHOW_LAST) begin
      cnt_d = '0;
      if (DEAD_CYCLES == 0) idx_d = idx_q + 2'd1;
      else state_d = GUARD;
    end else if (state_q == GUARD && cnt_q == GUARD_LAST) begin
      cnt_d = '0;
      state_d = SHOW;
      idx_d = idx_q + 2'd1;
    end
    // Outputs are registered from the next state so they line up with it.
    an_d = state_d == SHOW ? ~(4'b0001 << idx_d) : 4'hF;
    fd_d = idx_d == 2'd3 && (DEAD_CYCLES == 0 ? state_d == SHOW && cnt_d == SHOW_LAST
                                               : state_d == GUARD && cnt_d == GUARD_LAST);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= 2'd0;
      cnt_q <= '0;
      an_q <= 4'hF;
      fd_q <= 1'b0;
      act_q <= 16'hFFFF;
      pend_q <= 16'hFFFF;
      pf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      an_q <= an_d;
      fd_q <= fd_d;
      if (fd_q && bus.digits_valid) begin
        act_q <= bus.digits_in;
        pf_q <= 1'b0;
      end else if (fd_q && pf_q) begin
        act_q <= pend_q;
        pf_q <= 1'b0;
      end else if (bus.digits_valid) begin
        pend_q <= bus.digits_in;
        pf_q <= 1'b1;
      end
    end
  end
  assign raw = act_q[{idx_q, 2'b00} +: 4];
`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic [15:0] hi;
  assign hi = act_q >> {idx_q, 2'b00};
  assign code = (idx_q != 2'd0 && hi == 16'h0) ? BLANK_CODE : raw;
`else
  assign code = raw;
`endif
  assign bus.an = an_q;
  assign bus.frame_done = fd_q;
  seven_seg_decoder u_dec (.code_i(code), .seg_o(bus.seg));
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: two scanners (DEAD_CYCLES 2 and 0) checked every cycle against a frame-position model
module tb_seven_seg_scanner;
  localparam int DP = 8;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, dv = 1'b0, chkon = 1'b0;
  logic [15:0] din = 16'h0;
  int vec = 0, errs = 0;
  bit run[2];
  int p[2];
  logic [15:0] act[2], pend[2];
  bit pf[2];
  always #5 clk = ~clk;
  seven_seg_if b0 ();
  seven_seg_if b1 ();
  assign b0.en = en;
  assign b0.digits_in = din;
  assign b0.digits_valid = dv;
  assign b1.en = en;
  assign b1.digits_in = din;
  assign b1.digits_valid = dv;
  seven_seg_scanner #(.DIGIT_PERIOD(DP), .DEAD_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(b0));
  seven_seg_scanner #(.DIGIT_PERIOD(DP), .DEAD_CYCLES(0)) dut_nd (.clk(clk), .rst(rst), .bus(b1));

  function automatic logic [6:0] seg_of(logic [3:0] c);
    case (c)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      4'd10: return 7'b0001000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] code_of(logic [15:0] a, int k);
    logic [3:0] c;
    c = a[k*4+:4];
`ifdef SEVEN_SEG_LZ_BLANK_EN
    if (k > 0 && (a >> (k * 4)) == 16'h0) c = 4'hF;
`endif
    return c;
  endfunction

  function automatic int per_of(int k);
    return DP + (k == 0 ? 2 : 0);
  endfunction

  task automatic chk(string tag, int k, logic [15:0] obs, logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s dut%0d t=%0t got %h want %h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int per, fr, d, w;
      logic [3:0] ean;
      logic [6:0] oseg;
      per = per_of(k);
      fr = 4 * per;
      d = p[k] / per;
      w = p[k] % per;
      ean = (run[k] && w < DP) ? ~(4'b0001 << d) : 4'hF;
      oseg = k == 0 ? b0.seg : b1.seg;
      if (chkon) begin
        chk("an", k, k == 0 ? b0.an : b1.an, ean);
        chk("frame_done", k, k == 0 ? b0.frame_done : b1.frame_done, run[k] && p[k] == fr - 1);
        if (run[k] && w < DP) chk("seg", k, oseg, seg_of(code_of(act[k], d)));
      end
      if (rst) begin
        run[k] = 0;
        p[k] = 0;
        act[k] = 16'hFFFF;
        pend[k] = 16'hFFFF;
        pf[k] = 0;
      end else begin
        bit fdc;
        fdc = run[k] && p[k] == fr - 1;
        if (fdc && dv) begin
          act[k] = din;
          pf[k] = 0;
        end else if (fdc && pf[k]) begin
          act[k] = pend[k];
          pf[k] = 0;
        end else if (dv) begin
          pend[k] = din;
          pf[k] = 1;
        end
        if (!en) run[k] = 0;
        else if (!run[k]) begin
          run[k] = 1;
          p[k] = 0;
        end else p[k] = (p[k] + 1) % fr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_p(int target);
    int n = 0;
    while (!(run[0] && p[0] == target) && n < 200) begin
      step();
      n++;
    end
    chk("wait_pos", 0, 16'(run[0] && p[0] == target), 16'd1);
  endtask

  task automatic strobe(logic [15:0] v);
    din = v;
    dv = 1'b1;
    step();
    dv = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    chkon = 1'b1;
    step();
    rst = 1'b0;
    step();
    en = 1'b1;
    repeat (45) step();
    wait_p(15);
    strobe(16'h1234);
    repeat (90) step();
    wait_p(5);
    strobe(16'h1111);
    repeat (3) step();
    strobe(16'h5678);
    wait_p(39);
    strobe(16'h9999);
    repeat (45) step();
    wait_p(23);
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (20) step();
    strobe(16'h0070);
    repeat (90) step();
    strobe(16'h0000);
    repeat (90) step();
    strobe(16'hFEDB);
    repeat (90) step();
    strobe(16'hA0BC);
    repeat (90) step();
    wait_p(12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (50) step();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom % 50) != 0;
      dv = ($urandom % 8) == 0;
      din = 16'($urandom);
      step();
    end
    en = 1'b1;
    dv = 1'b0;
    repeat (90) step();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
